sig_pulse_scheduler: RTL and testbench

Round-robin scheduler that shares one single-input edge-triggered datapath block (`in_signal` → `out_signal`) among `N_REQ` requesters. It grants one requester at a time and drives a fixed-length pulse on `in_signal`. It then waits for the datapath response on `out_signal` and returns a per-requester completion or timeout strobe. A guard gap separates consecutive pulses. The block sits directly in front of the datapath instance and is the only driver of its `in_signal`.

---
 rtl/sig_sched_pkg.sv | 34 +++
 rtl/sig_pulse_scheduler_rr_pick.sv | 33 +++
 rtl/sig_pulse_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_sig_pulse_scheduler.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/sig_sched_pkg.sv
// sig_sched_pkg
//   Shared definitions for the pulse scheduler:
//   - sched_state_t : FSM state encoding (IDLE, DRIVE, WAIT_RSP, GAP)
//   - cnt_width()   : width of the shared phase counter
//   - sched_params_ok() : parameter legality, checked at elaboration
package sig_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRIVE    = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_GAP      = 2'd3
  } sched_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // One counter serves the pulse, the response wait and the guard gap, so it
  // must hold the largest of the three limits.
  function automatic int cnt_width(input int pulse_len, input int timeout, input int gap);
    return $clog2(max3(pulse_len, timeout, gap) + 1);
  endfunction

  function automatic bit sched_params_ok(input int n_req, input int pulse_len,
                                         input int timeout, input int gap);
    return (n_req >= 2) && (pulse_len >= 1) && (timeout >= 1) && (gap >= 0);
  endfunction

endpackage

// File: rtl/sig_pulse_scheduler_rr_pick.sv
// rr_pick
//   Combinational round-robin selector.
//   req   : request vector
//   ptr   : index of the most recently granted requester
//   valid : at least one request is set
//   idx   : first set request searching from ptr+1 upward with wrap
module rr_pick
  import sig_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic             valid,
  output logic [PTR_W-1:0] idx
);

  int cand;

  // Walk the offsets from farthest to nearest so the nearest set bit after
  // the pointer is the last (winning) assignment.
  always_comb begin
    valid = |req;
    idx   = '0;
    cand  = 0;
    for (int off = N_REQ; off >= 1; off--) begin
      cand = (int'(ptr) + off) % N_REQ;
      if (req[PTR_W'(cand)]) idx = PTR_W'(cand);
    end
  end

endmodule

// File: rtl/sig_pulse_scheduler.sv
// sig_pulse_scheduler
//   Shares one edge-triggered datapath block among N_REQ requesters. Grants
//   one requester at a time, drives a PULSE_LEN-cycle pulse on in_signal,
//   waits up to TIMEOUT cycles for out_signal, then strobes done or err for
//   the grantee and holds in_signal low for GAP cycles.
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   req        : level requests, held until done/err
//   gnt        : one-hot-or-zero current grant
//   done / err : one-cycle completion / timeout strobes per requester
//   busy       : scheduler is not idle
//   in_signal  : pulse to the datapath
//   out_signal : response from the datapath
module sig_pulse_scheduler
  import sig_sched_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int PULSE_LEN = 1,
  parameter int TIMEOUT   = 16,
  parameter int GAP       = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] err,
  output logic             busy,
  output logic             in_signal,
  input  logic             out_signal
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = cnt_width(PULSE_LEN, TIMEOUT, GAP);

  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = (GAP > 0) ? CNT_W'(GAP - 1) : '0;

  // With no guard gap the strobe edge returns straight to IDLE.
  localparam sched_state_t ST_AFTER_STROBE = (GAP > 0) ? ST_GAP : ST_IDLE;

  if (!sched_params_ok(N_REQ, PULSE_LEN, TIMEOUT, GAP)) begin : g_param_check
    $error("sig_pulse_scheduler: illegal parameter set");
  end

  sched_state_t     state_reg, state_next;
  logic [PTR_W-1:0] ptr_reg, ptr_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic             resp_seen_reg, resp_seen_next;
  logic [N_REQ-1:0] gnt_reg, gnt_next;
  logic [N_REQ-1:0] done_reg, done_next;
  logic [N_REQ-1:0] err_reg, err_next;
  logic             busy_reg, busy_next;
  logic             in_signal_reg, in_signal_next;

  // Only feed the in_signal spacing check.
  logic [CNT_W-1:0] low_run_reg;
  logic             fall_seen_reg;

  logic             pick_valid;
  logic [PTR_W-1:0] pick_idx;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req   (req),
    .ptr   (ptr_reg),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Saturating increment: the counter must never wrap back to a limit value.
  assign cnt_inc = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    cnt_next       = cnt_reg;
    resp_seen_next = resp_seen_reg;
    gnt_next       = gnt_reg;
    done_next      = '0;
    err_next       = '0;
    in_signal_next = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        if (pick_valid) begin
          gnt_next       = N_REQ'(1) << pick_idx;
          in_signal_next = 1'b1;
          ptr_next       = pick_idx;
          cnt_next       = '0;
          resp_seen_next = 1'b0;
          state_next     = ST_DRIVE;
        end
      end

      ST_DRIVE: begin
        // A response may arrive while the pulse is still high; remember it.
        resp_seen_next = resp_seen_reg | out_signal;
        if (cnt_reg == PULSE_LAST) begin
          cnt_next   = '0;
          state_next = ST_WAIT_RSP;
        end else begin
          in_signal_next = 1'b1;
          cnt_next       = cnt_inc;
        end
      end

      ST_WAIT_RSP: begin
        resp_seen_next = resp_seen_reg | out_signal;
        // Response is tested first so it beats a coincident timeout.
        if (out_signal || resp_seen_reg) begin
          done_next  = gnt_reg;
          gnt_next   = '0;
          cnt_next   = '0;
          state_next = ST_AFTER_STROBE;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          err_next   = gnt_reg;
          gnt_next   = '0;
          cnt_next   = '0;
          state_next = ST_AFTER_STROBE;
        end else begin
          cnt_next = cnt_inc;
        end
      end

      ST_GAP: begin
        if (cnt_reg == GAP_LAST) begin
          cnt_next   = '0;
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_inc;
        end
      end

      default: begin
        state_next = ST_IDLE;
        gnt_next   = '0;
        cnt_next   = '0;
      end
    endcase

    busy_next = (state_next != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      ptr_reg       <= PTR_W'(N_REQ - 1);
      cnt_reg       <= '0;
      resp_seen_reg <= 1'b0;
      gnt_reg       <= '0;
      done_reg      <= '0;
      err_reg       <= '0;
      busy_reg      <= 1'b0;
      in_signal_reg <= 1'b0;
      low_run_reg   <= '0;
      fall_seen_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      cnt_reg       <= cnt_next;
      resp_seen_reg <= resp_seen_next;
      gnt_reg       <= gnt_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
      busy_reg      <= busy_next;
      in_signal_reg <= in_signal_next;

      if (in_signal_reg)
        low_run_reg <= '0;
      else if (low_run_reg != CNT_MAX)
        low_run_reg <= low_run_reg + 1'b1;
      fall_seen_reg <= fall_seen_reg | (in_signal_reg & ~in_signal_next);

      assert ($onehot0(gnt_next));
      assert ($onehot0(done_next | err_next));
      assert (((done_next | err_next) & ~gnt_reg) == '0);
      // low_run_reg counts low samples before this edge; +1 includes this one.
      // Rises can only happen here, i.e. with rst low.
      if (!in_signal_reg && in_signal_next)
        assert (!fall_seen_reg || (int'(low_run_reg) + 1 >= GAP));
    end
  end

  assign gnt       = gnt_reg;
  assign done      = done_reg;
  assign err       = err_reg;
  assign busy      = busy_reg;
  assign in_signal = in_signal_reg;

endmodule

// File: tb/tb_sig_pulse_scheduler.sv
// Directed bench for sig_pulse_scheduler. Instance a uses the default
// parameters (PULSE_LEN=1, TIMEOUT=16, GAP=2); instance b uses PULSE_LEN=3,
// TIMEOUT=16, GAP=0. Clock and reset are shared.
module tb_sig_pulse_scheduler;

  logic       clk;
  logic       rst;
  logic [3:0] req_a, gnt_a, done_a, err_a;
  logic       busy_a, in_a, out_a;
  logic [3:0] req_b, gnt_b, done_b, err_b;
  logic       busy_b, in_b, out_b;

  int n_total = 0;
  int n_bad   = 0;

  sig_pulse_scheduler #(
    .N_REQ(4), .PULSE_LEN(1), .TIMEOUT(16), .GAP(2)
  ) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .gnt(gnt_a), .done(done_a), .err(err_a),
    .busy(busy_a), .in_signal(in_a), .out_signal(out_a)
  );

  sig_pulse_scheduler #(
    .N_REQ(4), .PULSE_LEN(3), .TIMEOUT(16), .GAP(0)
  ) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .gnt(gnt_b), .done(done_b), .err(err_b),
    .busy(busy_b), .in_signal(in_b), .out_signal(out_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] gnt_of(input bit sel);
    return sel ? gnt_b : gnt_a;
  endfunction

  function automatic logic [3:0] done_of(input bit sel);
    return sel ? done_b : done_a;
  endfunction

  function automatic logic [3:0] err_of(input bit sel);
    return sel ? err_b : err_a;
  endfunction

  function automatic logic in_of(input bit sel);
    return sel ? in_b : in_a;
  endfunction

  task automatic set_out(input bit sel, input logic v);
    if (sel) out_b = v;
    else     out_a = v;
  endtask

  task automatic drop_req(input bit sel, input logic [3:0] g);
    if (sel) req_b = req_b & ~g;
    else     req_a = req_a & ~g;
  endtask

  // One transaction: wait for the grant, raise out_signal so that it is
  // sampled on edge (grant edge + resp_edge) (0 = never), then expect the
  // strobe exp_lat edges after the grant edge.
  task automatic run_txn(input bit sel, input string tag, input logic [3:0] exp_gnt,
                         input int exp_wait, input int resp_edge, input bit exp_err,
                         input int exp_lat, input bit drop);
    int  waited;
    bit  got;
    waited = 0;
    do begin
      tick();
      waited++;
    end while (gnt_of(sel) == 4'b0000 && waited < 30);
    chk({tag, "_wait"}, waited, exp_wait);
    chk({tag, "_gnt"}, int'(gnt_of(sel)), int'(exp_gnt));
    chk({tag, "_in"}, int'(in_of(sel)), 1);
    set_out(sel, resp_edge == 1);
    got = 1'b0;
    for (int c = 1; c <= 40 && !got; c++) begin
      tick();
      if ((done_of(sel) | err_of(sel)) != 4'b0000) begin
        got = 1'b1;
        chk({tag, "_lat"}, c, exp_lat);
        chk({tag, "_done"}, int'(done_of(sel)), exp_err ? 0 : int'(exp_gnt));
        chk({tag, "_err"}, int'(err_of(sel)), exp_err ? int'(exp_gnt) : 0);
        if (drop) drop_req(sel, exp_gnt);
      end
      set_out(sel, (c + 1) == resp_edge);
    end
    if (!got) chk({tag, "_strobe_seen"}, 0, 1);
    set_out(sel, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_a = '0; req_b = '0; out_a = 1'b0; out_b = 1'b0;
    tick(); tick(); tick();
    chk("rst_gnt", int'(gnt_a), 0);
    chk("rst_in", int'(in_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done_err", int'(done_a | err_a), 0);
    chk("rst_b_in_gnt", int'({in_b, gnt_b}), 0);
    rst = 1'b0;

    // Single request, response sampled 2 edges after the grant edge.
    req_a = 4'b0010;
    tick();
    chk("t1_gnt", int'(gnt_a), 2);
    chk("t1_in_hi", int'(in_a), 1);
    chk("t1_busy", int'(busy_a), 1);
    tick();
    chk("t1_in_lo", int'(in_a), 0);
    chk("t1_gnt_hold", int'(gnt_a), 2);
    chk("t1_no_done", int'(done_a), 0);
    out_a = 1'b1;
    tick();
    chk("t1_done", int'(done_a), 2);
    chk("t1_gnt_clr", int'(gnt_a), 0);
    chk("t1_no_err", int'(err_a), 0);
    out_a = 1'b0; req_a = 4'b0000;
    tick();
    chk("t1_done_1cyc", int'(done_a), 0);
    chk("t1_busy_gap", int'(busy_a), 1);
    tick();
    chk("t1_busy_idle", int'(busy_a), 0);

    // Reset to restore the pointer, then all four request continuously.
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    req_a = 4'b1111;
    run_txn(0, "rr0", 4'b0001, 1, 2, 0, 2, 0);
    run_txn(0, "rr1", 4'b0010, 3, 2, 0, 2, 0);
    run_txn(0, "rr2", 4'b0100, 3, 2, 0, 2, 0);
    run_txn(0, "rr3", 4'b1000, 3, 2, 0, 2, 0);
    run_txn(0, "rr4", 4'b0001, 3, 2, 0, 2, 0);
    req_a = 4'b0000;
    tick(); tick(); tick(); tick();

    // Timeout on requester 1, then requester 2 served after the gap.
    req_a = 4'b0110;
    run_txn(0, "to1", 4'b0010, 1, 0, 1, 17, 1);
    run_txn(0, "to2", 4'b0100, 3, 2, 0, 2, 1);

    // PULSE_LEN=3: response during DRIVE, and at the timeout limit edge.
    req_b = 4'b0001;
    run_txn(1, "drv", 4'b0001, 1, 2, 0, 4, 1);
    req_b = 4'b0010;
    run_txn(1, "lim", 4'b0010, 1, 19, 0, 19, 1);

    // GAP=0 back-to-back: in_signal low over WAIT_RSP and IDLE only.
    req_b = 4'b1100;
    run_txn(1, "b2b0", 4'b0100, 1, 4, 0, 4, 1);
    chk("b2b_in_lo", int'(in_b), 0);
    run_txn(1, "b2b1", 4'b1000, 1, 4, 0, 4, 1);

    // Reset in the middle of DRIVE.
    req_b = 4'b0100;
    tick();
    chk("mr_gnt", int'(gnt_b), 4);
    tick();
    chk("mr_in_drive", int'(in_b), 1);
    #2 rst = 1'b1;
    #1;
    chk("mr_in_async", int'(in_b), 0);
    chk("mr_gnt_async", int'(gnt_b), 0);
    chk("mr_busy_async", int'(busy_b), 0);
    req_b = 4'b0101;
    tick();
    chk("mr_no_strobe", int'(done_b | err_b), 0);
    tick();
    rst = 1'b0;
    run_txn(1, "pr0", 4'b0001, 1, 2, 0, 4, 1);
    run_txn(1, "pr1", 4'b0100, 1, 2, 0, 4, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
